circulant_buffered_topology: RTL and testbench



---
 rtl/circulant_buffered_topology_pkg.sv | 38 +++
 rtl/circulant_buffered_topology_link_fifo.sv | 81 ++++++++
 rtl/circulant_buffered_topology.sv | 89 ++++++++
 tb/tb_circulant_buffered_topology.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/circulant_buffered_topology_pkg.sv
// Shared constants and helpers for the buffered circulant topology:
// port numbering, reverse-port pairing and modular neighbour lookup.
package circ_pkg;

    localparam int PORTS_NUM  = 4;
    localparam int P_PLUS_S0  = 0;
    localparam int P_MINUS_S0 = 1;
    localparam int P_PLUS_S1  = 2;
    localparam int P_MINUS_S1 = 3;

    // Port on which the destination router receives a flit sent on 'port'.
    function automatic int rev_port(input int port);
        int r;
        case (port)
            P_PLUS_S0:  r = P_MINUS_S0;
            P_MINUS_S0: r = P_PLUS_S0;
            P_PLUS_S1:  r = P_MINUS_S1;
            P_MINUS_S1: r = P_PLUS_S1;
            default:    r = port;
        endcase
        return r;
    endfunction

    // Node reached from 'node' through 'port', all arithmetic mod nodes_num.
    function automatic int neighbour(input int node, input int port,
                                     input int nodes_num, input int s0, input int s1);
        int off;
        case (port)
            P_PLUS_S0:  off = s0;
            P_MINUS_S0: off = nodes_num - s0;
            P_PLUS_S1:  off = s1;
            P_MINUS_S1: off = nodes_num - s1;
            default:    off = 0;
        endcase
        return (node + off) % nodes_num;
    endfunction

endpackage

// File: rtl/circulant_buffered_topology_link_fifo.sv
// link_fifo: one directed link of the topology. Registered head word, so a
// flit pushed on edge k becomes visible after edge k (no fall-through) and
// the head holds the last popped word while the FIFO is empty.
module link_fifo #(
    parameter int BUS_SIZE   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                wr_valid_i,
    input  logic [BUS_SIZE-1:0] wr_data_i,
    output logic                wr_ready_o,
    input  logic                rd_ready_i,
    output logic                rd_valid_o,
    output logic [BUS_SIZE-1:0] rd_data_o
);

    localparam int             AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    CNT_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]    CNT_ZERO  = (AW+1)'(0);
    localparam logic [AW:0]    CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0]  PTR_ONE   = AW'(1);

    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic [BUS_SIZE-1:0] head_q, head_d;
    logic [BUS_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic                push_s, pop_s;

    // Ready/valid come from stored state only, never from the opposite side.
    assign wr_ready_o = (count_q != CNT_FULL);
    assign rd_valid_o = (count_q != CNT_ZERO);
    assign rd_data_o  = head_q;

    // Next-state for pointers, occupancy and the registered head word.
    always_comb begin
        push_s   = wr_valid_i & wr_ready_o;
        pop_s    = rd_valid_o & rd_ready_i;
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        // The incoming word is the new head when nothing else is left to show.
        if (count_d == CNT_ZERO) begin
            head_d = head_q;
        end else if ((count_q == CNT_ZERO) || (pop_s && (count_q == CNT_ONE))) begin
            head_d = wr_data_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Control state and head register, flushed by reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= CNT_ZERO;
            head_q   <= {BUS_SIZE{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // Storage array; contents are only observed through count-qualified reads.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

endmodule

// File: rtl/circulant_buffered_topology.sv
// circulant_buffered_topology: circulant graph C(NODES_NUM; S0, S1) with a
// link_fifo on every directed link. Wiring only, plus optional per-node
// stall counters enabled by the macro CIRC_LINK_STATS_EN.
module circulant_buffered_topology
    import circ_pkg::*;
#(
    parameter int BUS_SIZE   = 4,
    parameter int NODES_NUM  = 4,
    parameter int S0         = 1,
    parameter int S1         = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_n_i,
    input  logic [NODES_NUM*PORTS_NUM*BUS_SIZE-1:0] data_i,
    input  logic [NODES_NUM*PORTS_NUM-1:0]          wr_ready_out_i,
    input  logic [NODES_NUM*PORTS_NUM-1:0]          r_ready_out_i,
    output logic [NODES_NUM*PORTS_NUM*BUS_SIZE-1:0] data_o,
    output logic [NODES_NUM*PORTS_NUM-1:0]          wr_ready_in_o,
    output logic [NODES_NUM*PORTS_NUM-1:0]          r_ready_in_o
`ifdef CIRC_LINK_STATS_EN
    ,
    output logic [NODES_NUM*16-1:0]                 stall_cnt_o
`endif
);

    localparam int LINKS = NODES_NUM * PORTS_NUM;

    logic [LINKS-1:0]               valid_s;
    logic [LINKS-1:0][BUS_SIZE-1:0] head_s;

    // One FIFO per writer port; its reader is the neighbour's reverse port.
    for (genvar i = 0; i < LINKS; i++) begin : g_link
        localparam int RD_IDX = neighbour(i / PORTS_NUM, i % PORTS_NUM, NODES_NUM, S0, S1)
                                * PORTS_NUM + rev_port(i % PORTS_NUM);
        link_fifo #(
            .BUS_SIZE   (BUS_SIZE),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i      (clk_i),
            .rst_n_i    (rst_n_i),
            .wr_valid_i (wr_ready_out_i[i]),
            .wr_data_i  (data_i[i*BUS_SIZE +: BUS_SIZE]),
            .wr_ready_o (r_ready_in_o[i]),
            .rd_ready_i (r_ready_out_i[RD_IDX]),
            .rd_valid_o (valid_s[i]),
            .rd_data_o  (head_s[i])
        );
    end

    // Each reader port is fed by the FIFO of the neighbour on the same port
    // direction, written on the reverse port.
    for (genvar j = 0; j < LINKS; j++) begin : g_reader
        localparam int SRC = neighbour(j / PORTS_NUM, j % PORTS_NUM, NODES_NUM, S0, S1)
                             * PORTS_NUM + rev_port(j % PORTS_NUM);
        assign wr_ready_in_o[j]                  = valid_s[SRC];
        assign data_o[j*BUS_SIZE +: BUS_SIZE]    = head_s[SRC];
    end

`ifdef CIRC_LINK_STATS_EN
    logic [NODES_NUM-1:0][15:0] stall_cnt_q, stall_cnt_d;
    logic [NODES_NUM-1:0]       stall_s;

    // Count cycles where a node offers a flit to a full link; saturate at max.
    always_comb begin
        for (int n = 0; n < NODES_NUM; n++) begin
            stall_s[n] = |(wr_ready_out_i[n*PORTS_NUM +: PORTS_NUM] &
                           ~r_ready_in_o[n*PORTS_NUM +: PORTS_NUM]);
            if (stall_s[n] && (stall_cnt_q[n] != 16'hFFFF)) begin
                stall_cnt_d[n] = stall_cnt_q[n] + 16'd1;
            end else begin
                stall_cnt_d[n] = stall_cnt_q[n];
            end
        end
    end

    // Stall counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_circulant_buffered_topology.sv
// Randomised + directed bench for circulant_buffered_topology (N=4, S0=1,
// S1=2, D=4). A queue-per-link model predicts every output each cycle.
module tb_circulant_buffered_topology;

    localparam int N = 4;
    localparam int S0 = 1;
    localparam int S1 = 2;
    localparam int D = 4;
    localparam int B = 4;
    localparam int L = N * 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [L*B-1:0]   data_i = '0;
    logic [L-1:0]     wr_out = '0;
    logic [L-1:0]     rd_out = '0;
    logic [L*B-1:0]   data_o;
    logic [L-1:0]     wr_in;
    logic [L-1:0]     r_in;
`ifdef CIRC_LINK_STATS_EN
    logic [N*16-1:0]  stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [B-1:0] mq [L][$];
    int           stall_m [N];

    always #5 clk = ~clk;

    circulant_buffered_topology #(
        .BUS_SIZE(B), .NODES_NUM(N), .S0(S0), .S1(S1), .FIFO_DEPTH(D)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .data_i         (data_i),
        .wr_ready_out_i (wr_out),
        .r_ready_out_i  (rd_out),
        .data_o         (data_o),
        .wr_ready_in_o  (wr_in),
        .r_ready_in_o   (r_in)
`ifdef CIRC_LINK_STATS_EN
        ,
        .stall_cnt_o    (stall_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reader index (node*4+port) that receives what link i carries.
    function automatic int dest_of(input int i);
        int node, p, off, d;
        node = i / 4;
        p = i % 4;
        case (p)
            0: off = S0;
            1: off = -S0;
            2: off = S1;
            default: off = -S1;
        endcase
        d = ((node + off) % N + N) % N;
        return d * 4 + (p ^ 1);
    endfunction

    function automatic int src_of(input int j);
        for (int i = 0; i < L; i++) begin
            if (dest_of(i) == j) return i;
        end
        return 0;
    endfunction

    // Reference model: transfer decisions from pre-edge queue occupancy.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < L; i++) mq[i].delete();
            for (int n = 0; n < N; n++) stall_m[n] = 0;
        end else begin
            bit [L-1:0] pops, pushes;
            for (int i = 0; i < L; i++) begin
                pops[i]   = (mq[i].size() > 0) && rd_out[dest_of(i)];
                pushes[i] = wr_out[i] && (mq[i].size() < D);
            end
            for (int n = 0; n < N; n++) begin
                bit st;
                st = 1'b0;
                for (int p = 0; p < 4; p++)
                    if (wr_out[n*4+p] && mq[n*4+p].size() == D) st = 1'b1;
                if (st && stall_m[n] < 65535) stall_m[n]++;
            end
            for (int i = 0; i < L; i++) begin
                if (pops[i]) void'(mq[i].pop_front());
                if (pushes[i]) mq[i].push_back(data_i[i*B +: B]);
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [L-1:0] ev, er;
            for (int j = 0; j < L; j++) ev[j] = (mq[src_of(j)].size() > 0);
            for (int i = 0; i < L; i++) er[i] = (mq[i].size() < D);
            check("valid_vec", 64'(wr_in), 64'(ev));
            check("ready_vec", 64'(r_in), 64'(er));
            for (int j = 0; j < L; j++) begin
                if (ev[j]) check("head_data", 64'(data_o[j*B +: B]), 64'(mq[src_of(j)][0]));
            end
`ifdef CIRC_LINK_STATS_EN
            for (int n = 0; n < N; n++)
                check("stall_cnt", 64'(stall_cnt[n*16 +: 16]), 64'(stall_m[n]));
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_out = '0;
        rd_out = '0;
        rst_n  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        do_reset();
        // Reset state
        check("rst_valid", 64'(wr_in), 64'h0);
        check("rst_ready", 64'(r_in), 64'hFFFF);
        check("rst_data", data_o, 64'h0);

        // Single flit node0 p0 -> node1 p1 (index 5), reader ready
        rd_out = 16'h0020;
        wr_out = 16'h0001;
        data_i[3:0] = 4'hF;
        tick();
        wr_out = '0;
        check("t1_valid", 64'(wr_in[5]), 64'h1);
        check("t1_data", 64'(data_o[23:20]), 64'hF);
        tick();
        check("t1_popped", 64'(wr_in[5]), 64'h0);
        rd_out = '0;

        // Fill to full with reader stalled; the 5th word is refused
        for (int v = 1; v <= 5; v++) begin
            data_i[3:0] = 4'(v);
            wr_out = 16'h0001;
            tick();
            check("fill_ready", 64'(r_in[0]), (v < 4) ? 64'h1 : 64'h0);
        end
        check("fill_head", 64'(data_o[23:20]), 64'h1);
        // Full with simultaneous pop and push attempt
        data_i[3:0] = 4'h6;
        rd_out = 16'h0020;
        tick();
        wr_out = '0;
        check("full_pop_ready", 64'(r_in[0]), 64'h1);
        check("full_pop_head", 64'(data_o[23:20]), 64'h2);
        tick();
        check("drain3", 64'(data_o[23:20]), 64'h3);
        tick();
        check("drain4", 64'(data_o[23:20]), 64'h4);
        tick();
        check("drained", 64'(wr_in[5]), 64'h0);
        rd_out = '0;

        // 2*S1 == N: two distinct links between node0 and node2
        data_i[11:8]  = 4'hA;
        data_i[15:12] = 4'h5;
        wr_out = 16'h000C;
        tick();
        wr_out = '0;
        check("coinc_valid", 64'(wr_in), 64'h0C00);
        check("coinc_p3", 64'(data_o[47:44]), 64'hA);
        check("coinc_p2", 64'(data_o[43:40]), 64'h5);
        rd_out = 16'h0C00;
        tick();
        rd_out = '0;

        // Reset while three flits are queued in L(0,0)
        for (int v = 7; v <= 9; v++) begin
            data_i[3:0] = 4'(v);
            wr_out = 16'h0001;
            tick();
        end
        wr_out = '0;
        check("q3_valid", 64'(wr_in[5]), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(wr_in), 64'h0);
        check("arst_ready", 64'(r_in), 64'hFFFF);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", 64'(wr_in), 64'h0);
        check("post_rst_ready", 64'(r_in), 64'hFFFF);

`ifdef CIRC_LINK_STATS_EN
        do_reset();
        wr_out = 16'h0001;
        for (int c = 0; c < 4 + 10; c++) tick();
        check("stall_10", 64'(stall_cnt[15:0]), 64'd10);
        for (int c = 0; c < 65530; c++) tick();
        check("stall_sat", 64'(stall_cnt[15:0]), 64'hFFFF);
        do_reset();
`endif

        // Randomised traffic with alternating backpressure density
        for (int c = 0; c < 3000; c++) begin
            data_i = {$urandom, $urandom};
            wr_out = 16'($urandom);
            if ((c % 400) < 200) rd_out = 16'($urandom & $urandom);
            else                 rd_out = 16'($urandom | $urandom);
            tick();
        end
        wr_out = '0;
        rd_out = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
